switch_key_input: RTL and testbench
===================================

// Module: switch_key_input
// PURPOSE
//  Memory-mapped input peripheral on the P8 system bus: the read-side counterpart of the tube output device.
//  Samples 64 DIP switches and 8 user keys, synchronises and debounces them, and exposes levels to the CPU.
//  Latches key-press events (write-1-to-clear) and raises a maskable interrupt request to the CP0/bridge.
// PARAMETERS
//  TICK_DIV    100000  clock cycles per debounce sample tick (1 ms at 100 MHz; bench overrides to 4)
//  DB_SAMPLES  4       consecutive equal samples required before a debounced bit changes (>=2)
// PORTS
//  CLK         in   1   system clock, single clock domain
//  RST         in   1   synchronous reset, active-high
//  WE          in   1   bus write enable for this device
//  WD          in   32  bus write data
//  innerADDR   in   3   word offset within device
//  RD          out  32  bus read data, combinational from registers
//  dip_sw_n    in   64  raw DIP switch pins, active-low, asynchronous
//  key_n       in   8   raw user key pins, active-low, asynchronous
//  irq         out  1   interrupt request, registered, level
// BEHAVIOUR
//  Register map (read: 1 = switch on / key pressed):
//   0: dip[31:0]   1: dip[63:32]   2: {24'd0, key_lvl}   3: {24'd0, key_evt}   4: {24'd0, irq_mask}
//   5-7: read 0. Writes to 0,1,2,5,6,7 ignored.
//  Reset: sync stages, sample shift regs, debounced regs, key_evt, irq_mask, tick counter, irq all 0
//   (shift/sync regs hold inverted value, i.e. "released/off").
//  Input path per bit: invert, 2-FF synchroniser, then debounce sampled only on tick.
//  Tick: counter 0..TICK_DIV-1, tick asserted for one cycle when counter == TICK_DIV-1, then wraps to 0.
//  Debounce: on tick, shift synced bit into DB_SAMPLES-deep history; if all DB_SAMPLES entries equal,
//   debounced bit <= that value, else hold. Debounced bit updates on the cycle after the qualifying tick.
//  Latency, raw edge to RD change: <= 2 + TICK_DIV*DB_SAMPLES + 1 cycles; any pulse shorter than
//   (DB_SAMPLES-1)*TICK_DIV cycles never changes the debounced value.
//  key_evt[i] set on debounced key_lvl[i] 0->1 transition (one cycle after key_lvl rises). Release: no event.
//  WE && innerADDR==3: key_evt <= key_evt & ~WD[7:0]. Same-cycle set and clear on one bit: set wins.
//  WE && innerADDR==4: irq_mask <= WD[7:0].
//  irq <= |(key_evt & irq_mask) every cycle; one cycle after the event/mask change that causes it.
//  RD reflects register state before any same-cycle write (write visible next cycle).
//  Reset mid-debounce: all history discarded; a key still held after reset re-qualifies from scratch and
//   generates a fresh event.
// STRUCTURE
//  Shared package/header: register offset constants (DIP_LO, DIP_HI, KEY_LVL, KEY_EVT, IRQ_MASK).
//  Sub-module input_debounce #(WIDTH, DB_SAMPLES): synchroniser + history + debounced output for a vector,
//   driven by the shared tick; instantiated once for dip_sw_n (WIDTH 64) and once for key_n (WIDTH 8).
//  Top holds the tick counter, event latch, mask, irq register and read mux.
// TESTING (TICK_DIV=4, DB_SAMPLES=3)
//  Reset, all pins high -> RD reads 0 at offsets 0-7, irq=0.
//  dip_sw_n = ~64'h0123_4567_89AB_CDEF held 20 cycles -> offset0 = 32'h89AB_CDEF, offset1 = 32'h0123_4567.
//  key_n[0] low for 5 cycles then high -> offset2 stays 0, offset3 stays 0 throughout.
//  key_n[2] held low, mask=0x04 -> offset2=0x04 within 16 cycles, offset3=0x04, irq=1 next cycle.
//  Write 0x04 to offset3 in the cycle key 5 event sets -> offset3=0x20, irq=0 (mask 0x04) one cycle later.
//  Assert RST for 1 cycle with key 2 held -> all regs 0, then offset3=0x04 again after re-debounce.

Source files
------------

// File: rtl/switch_key_input_pkg.sv
// rtl/switch_key_input_pkg.sv - shared constants for the switch/key input peripheral
// Purpose: register word offsets and vector widths used by the top and the bench.
// Ports: none (package).
package switch_key_input_pkg;

   localparam logic [2:0] DIP_LO   = 3'd0;
   localparam logic [2:0] DIP_HI   = 3'd1;
   localparam logic [2:0] KEY_LVL  = 3'd2;
   localparam logic [2:0] KEY_EVT  = 3'd3;
   localparam logic [2:0] IRQ_MASK = 3'd4;

   localparam int NUM_DIP = 64;
   localparam int NUM_KEY = 8;

endpackage

// File: rtl/switch_key_input_debounce.sv
// rtl/switch_key_input_debounce.sv - synchroniser plus tick-sampled debounce for a pin vector
// Purpose: invert active-low asynchronous pins, synchronise through two flops, and accept
//          a new level only after DB_SAMPLES equal samples taken on consecutive ticks.
// Ports:
//   clk_i     in   1      system clock
//   rst_i     in   1      synchronous reset, active-high
//   tick_i    in   1      one-cycle sample strobe shared by all instances
//   raw_n_i   in   WIDTH  raw active-low pins
//   level_o   out  WIDTH  debounced level, 1 = on/pressed
module input_debounce #(
   parameter int WIDTH      = 8,
   parameter int DB_SAMPLES = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tick_i,
   input  logic [WIDTH-1:0] raw_n_i,
   output logic [WIDTH-1:0] level_o
);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] level_q;
   logic [WIDTH-1:0] level_d;
   logic [WIDTH-1:0] hist_q [DB_SAMPLES];
   logic [WIDTH-1:0] hist_d [DB_SAMPLES];
   logic [WIDTH-1:0] all_one;
   logic [WIDTH-1:0] all_zero;

   // Qualification looks at the history including the sample being shifted in this tick,
   // so the level register changes on the edge that ends the qualifying tick cycle.
   always_comb begin
      hist_d[0] = sync2_q;
      for (int i = 1; i < DB_SAMPLES; i++) begin
         hist_d[i] = hist_q[i-1];
      end
      all_one  = '1;
      all_zero = '1;
      for (int i = 0; i < DB_SAMPLES; i++) begin
         all_one  = all_one & hist_d[i];
         all_zero = all_zero & ~hist_d[i];
      end
      level_d = (level_q | all_one) & ~all_zero;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         for (int i = 0; i < DB_SAMPLES; i++) begin
            hist_q[i] <= '0;
         end
      end else begin
         sync1_q <= ~raw_n_i;
         sync2_q <= sync1_q;
         if (tick_i) begin
            hist_q  <= hist_d;
            level_q <= level_d;
         end
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/switch_key_input.sv
// rtl/switch_key_input.sv - memory-mapped DIP switch and user key input device
// Purpose: debounced switch/key levels, write-1-to-clear key-press events and a masked
//          level interrupt, read through a combinational register mux.
// Ports:
//   CLK        in   1   system clock
//   RST        in   1   synchronous reset, active-high
//   WE         in   1   bus write enable
//   WD         in   32  bus write data
//   innerADDR  in   3   word offset within the device
//   RD         out  32  bus read data (pre-write register state)
//   dip_sw_n   in   64  raw DIP switch pins, active-low
//   key_n      in   8   raw user key pins, active-low
//   irq        out  1   registered interrupt request
module switch_key_input
   import switch_key_input_pkg::*;
#(
   parameter int TICK_DIV   = 100000,
   parameter int DB_SAMPLES = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 WE,
   input  logic [31:0]          WD,
   input  logic [2:0]           innerADDR,
   output logic [31:0]          RD,
   input  logic [NUM_DIP-1:0]   dip_sw_n,
   input  logic [NUM_KEY-1:0]   key_n,
   output logic                 irq
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               tick;
   logic [NUM_DIP-1:0] dip_lvl;
   logic [NUM_KEY-1:0] key_lvl;
   logic [NUM_KEY-1:0] key_prev_q;
   logic [NUM_KEY-1:0] key_evt_q, key_evt_d;
   logic [NUM_KEY-1:0] irq_mask_q, irq_mask_d;
   logic               irq_q, irq_d;
   logic               wd_hi_unused;

   // Only the low byte of write data carries register content.
   assign wd_hi_unused = ^WD[31:8];

   assign tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
   assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

   input_debounce #(.WIDTH(NUM_DIP), .DB_SAMPLES(DB_SAMPLES)) u_dip_db (
      .clk_i   (CLK),
      .rst_i   (RST),
      .tick_i  (tick),
      .raw_n_i (dip_sw_n),
      .level_o (dip_lvl)
   );

   input_debounce #(.WIDTH(NUM_KEY), .DB_SAMPLES(DB_SAMPLES)) u_key_db (
      .clk_i   (CLK),
      .rst_i   (RST),
      .tick_i  (tick),
      .raw_n_i (key_n),
      .level_o (key_lvl)
   );

   always_comb begin
      key_evt_d  = key_evt_q;
      irq_mask_d = irq_mask_q;
      if (WE && innerADDR == KEY_EVT) begin
         key_evt_d = key_evt_q & ~WD[7:0];
      end
      if (WE && innerADDR == IRQ_MASK) begin
         irq_mask_d = WD[7:0];
      end
      // Rising-edge set is applied after the clear so a same-cycle set wins.
      key_evt_d = key_evt_d | (key_lvl & ~key_prev_q);
      irq_d     = |(key_evt_q & irq_mask_q);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q      <= '0;
         key_prev_q <= '0;
         key_evt_q  <= '0;
         irq_mask_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         key_prev_q <= key_lvl;
         key_evt_q  <= key_evt_d;
         irq_mask_q <= irq_mask_d;
         irq_q      <= irq_d;
      end
   end

   always_comb begin
      RD = '0;
      case (innerADDR)
         DIP_LO:   RD = dip_lvl[31:0];
         DIP_HI:   RD = dip_lvl[63:32];
         KEY_LVL:  RD = {24'd0, key_lvl};
         KEY_EVT:  RD = {24'd0, key_evt_q};
         IRQ_MASK: RD = {24'd0, irq_mask_q};
         default:  RD = '0;
      endcase
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_switch_key_input.sv
// tb/tb_switch_key_input.sv - directed self-checking bench for switch_key_input
module tb_switch_key_input;

   logic        CLK = 1'b0;
   logic        RST;
   logic        WE;
   logic [31:0] WD;
   logic [2:0]  innerADDR;
   logic [31:0] RD;
   logic [63:0] dip_sw_n;
   logic [7:0]  key_n;
   logic        irq;

   int checks = 0;
   int errors = 0;

   switch_key_input #(.TICK_DIV(4), .DB_SAMPLES(3)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .WE        (WE),
      .WD        (WD),
      .innerADDR (innerADDR),
      .RD        (RD),
      .dip_sw_n  (dip_sw_n),
      .key_n     (key_n),
      .irq       (irq)
   );

   always #5 CLK = ~CLK;

   task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
      @(negedge CLK);
      WE = 1'b1; innerADDR = addr; WD = data;
      @(negedge CLK);
      WE = 1'b0;
   endtask

   task automatic test_reset;
      RST = 1'b1; WE = 1'b0; WD = '0; innerADDR = '0;
      dip_sw_n = '1; key_n = '1;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      for (int a = 0; a < 8; a++) begin
         @(negedge CLK);
         innerADDR = a[2:0];
         #1;
         checks++;
         if (RD !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd[%0d] got %h expected %h", a, RD, 32'h0);
         end
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq got %b expected 0", irq);
      end
   endtask

   task automatic test_dip;
      logic [63:0] pat;
      pat = 64'h0123_4567_89AB_CDEF;
      @(negedge CLK);
      dip_sw_n = ~pat;
      repeat (20) @(negedge CLK);
      innerADDR = 3'd0; #1;
      checks++;
      if (RD !== 32'h89AB_CDEF) begin
         errors++;
         $display("FAIL dip_lo got %h expected %h", RD, 32'h89AB_CDEF);
      end
      @(negedge CLK);
      innerADDR = 3'd1; #1;
      checks++;
      if (RD !== 32'h0123_4567) begin
         errors++;
         $display("FAIL dip_hi got %h expected %h", RD, 32'h0123_4567);
      end
   endtask

   task automatic test_glitch;
      @(negedge CLK);
      key_n[0] = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (c == 4) key_n[0] = 1'b1;
         innerADDR = (c % 2 == 0) ? 3'd2 : 3'd3;
         #1;
         checks++;
         if (RD !== 32'h0) begin
            errors++;
            $display("FAIL glitch_off%0d cycle %0d got %h expected %h", innerADDR, c, RD, 32'h0);
         end
      end
   endtask

   task automatic test_key_irq;
      bit found;
      // Mask write: old value on RD during the write cycle, new value after.
      @(negedge CLK);
      WE = 1'b1; innerADDR = 3'd4; WD = 32'h04;
      #1;
      checks++;
      if (RD !== 32'h0) begin
         errors++;
         $display("FAIL mask_same_cycle got %h expected %h", RD, 32'h0);
      end
      @(negedge CLK);
      WE = 1'b0;
      #1;
      checks++;
      if (RD !== 32'h04) begin
         errors++;
         $display("FAIL mask_next_cycle got %h expected %h", RD, 32'h04);
      end
      key_n[2] = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 16 && !found; c++) begin
         @(negedge CLK);
         innerADDR = 3'd2; #1;
         if (RD === 32'h04) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL key2_level got %h expected %h within 16 cycles", RD, 32'h04);
      end
      innerADDR = 3'd3; #1;
      checks++;
      if (RD !== 32'h0) begin
         errors++;
         $display("FAIL key2_evt_early got %h expected %h", RD, 32'h0);
      end
      @(negedge CLK);
      #1;
      checks++;
      if (RD !== 32'h04) begin
         errors++;
         $display("FAIL key2_evt got %h expected %h", RD, 32'h04);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL key2_irq_early got %b expected 0", irq);
      end
      @(negedge CLK);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL key2_irq got %b expected 1", irq);
      end
   endtask

   task automatic test_back_to_back;
      bit found;
      // Clear key 2 in the cycle key 5 sets: different bits, both take effect.
      key_n[5] = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 16 && !found; c++) begin
         @(negedge CLK);
         innerADDR = 3'd2; #1;
         if (RD[5] === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL key5_level got %h expected bit5 set within 16 cycles", RD);
      end
      WE = 1'b1; innerADDR = 3'd3; WD = 32'h04;
      @(negedge CLK);
      WE = 1'b0; #1;
      checks++;
      if (RD !== 32'h20) begin
         errors++;
         $display("FAIL clr2_set5_evt got %h expected %h", RD, 32'h20);
      end
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL clr2_irq_hold got %b expected 1", irq);
      end
      @(negedge CLK);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL clr2_irq_drop got %b expected 0", irq);
      end
      // Clear key 6 in the cycle key 6 sets: set wins.
      key_n[6] = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 16 && !found; c++) begin
         @(negedge CLK);
         innerADDR = 3'd2; #1;
         if (RD[6] === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL key6_level got %h expected bit6 set within 16 cycles", RD);
      end
      WE = 1'b1; innerADDR = 3'd3; WD = 32'h40;
      @(negedge CLK);
      WE = 1'b0; #1;
      checks++;
      if (RD !== 32'h60) begin
         errors++;
         $display("FAIL set_wins_evt got %h expected %h", RD, 32'h60);
      end
      key_n[5] = 1'b1;
      key_n[6] = 1'b1;
      bus_write(3'd3, 32'h60);
      innerADDR = 3'd3; #1;
      checks++;
      if (RD !== 32'h0) begin
         errors++;
         $display("FAIL w1c_all got %h expected %h", RD, 32'h0);
      end
      repeat (20) @(negedge CLK);
      innerADDR = 3'd2; #1;
      checks++;
      if (RD !== 32'h04) begin
         errors++;
         $display("FAIL release_level got %h expected %h", RD, 32'h04);
      end
      @(negedge CLK);
      innerADDR = 3'd3; #1;
      checks++;
      if (RD !== 32'h0) begin
         errors++;
         $display("FAIL release_no_evt got %h expected %h", RD, 32'h0);
      end
   endtask

   task automatic test_reset_mid;
      bit found;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      for (int a = 0; a < 5; a++) begin
         innerADDR = a[2:0]; #1;
         checks++;
         if (RD !== 32'h0) begin
            errors++;
            $display("FAIL midreset_rd[%0d] got %h expected %h", a, RD, 32'h0);
         end
         @(negedge CLK);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL midreset_irq got %b expected 0", irq);
      end
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge CLK);
         innerADDR = 3'd3; #1;
         if (RD !== 32'h0) found = 1'b1;
      end
      checks++;
      if (RD !== 32'h04) begin
         errors++;
         $display("FAIL requalify_evt got %h expected %h", RD, 32'h04);
      end
      @(negedge CLK);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL requalify_irq_masked got %b expected 0", irq);
      end
      bus_write(3'd4, 32'h04);
      @(negedge CLK);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL unmask_irq got %b expected 1", irq);
      end
   endtask

   initial begin
      test_reset();
      test_dip();
      test_glitch();
      test_key_irq();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
